// File: rtl/enoc_adaptive_route_calc_pkg.sv
// Shared types for the adaptive route calculator: port indices, one-hot codes,
// per-dimension direction, controller states and a width helper.
package enoc_pkg;

  typedef enum logic [2:0] {P_C, P_N, P_E, P_S, P_W} port_e;

  localparam logic [4:0] OH_NONE = 5'b00000;
  localparam logic [4:0] OH_C    = 5'b10000;
  localparam logic [4:0] OH_N    = 5'b01000;
  localparam logic [4:0] OH_E    = 5'b00100;
  localparam logic [4:0] OH_S    = 5'b00010;
  localparam logic [4:0] OH_W    = 5'b00001;

  typedef enum logic [1:0] {DIR_NONE, DIR_POS, DIR_NEG} dir_e;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_ESCAPE} state_e;

  // Bits needed to index n items; never below 1 so single-node dimensions keep a port.
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic [4:0] port_oh(input port_e p);
    return OH_C >> p;
  endfunction

endpackage

// File: rtl/enoc_adaptive_route_calc_if.sv
// Destination/request handshake bundle between the input unit, the route
// calculator and the switch allocator.
interface enoc_adaptive_route_calc_if #(
  parameter int XW = 2,
  parameter int YW = 2,
  parameter int CW = 3
);
  logic [XW-1:0]   i_x_dest;
  logic [YW-1:0]   i_y_dest;
  logic            i_val;
  logic            o_rdy;
  logic [4*CW-1:0] i_credit;
  logic [4:0]      o_output_req;
  logic            o_val;
  logic            i_rdy;
  logic            o_wrap;
  logic            o_err;

  modport slave (
    input  i_x_dest, i_y_dest, i_val, i_credit, i_rdy,
    output o_rdy, o_output_req, o_val, o_wrap, o_err
  );

  modport master (
    output i_x_dest, i_y_dest, i_val, i_credit, i_rdy,
    input  o_rdy, o_output_req, o_val, o_wrap, o_err
  );
endinterface

// File: rtl/enoc_adaptive_route_calc_dim_dir.sv
// Direction of travel along one dimension for a mesh or torus ring of N nodes.
module enoc_dim_dir
  import enoc_pkg::*;
#(
  parameter int N     = 4,
  parameter int LOC   = 0,
  parameter int TORUS = 0,
  parameter int W     = 2
) (
  input  logic [W-1:0] dest,
  output dir_e         dir
);
  localparam logic [W:0] N_V   = N[W:0];
  localparam logic [W:0] LOC_V = LOC[W:0];

  logic [W:0] d_ext;
  logic [W:0] fwd;
  logic [W:0] bwd;

  always_comb begin
    d_ext = {1'b0, dest};
    fwd   = (d_ext >= LOC_V) ? (d_ext - LOC_V) : (d_ext + N_V - LOC_V);
    bwd   = N_V - fwd;
    dir   = DIR_NONE;
    if (N > 1) begin
      if (TORUS != 0) begin
        // equal distance both ways resolves to the positive link
        if (fwd != '0) dir = (fwd <= bwd) ? DIR_POS : DIR_NEG;
      end else if (d_ext > LOC_V) begin
        dir = DIR_POS;
      end else if (d_ext < LOC_V) begin
        dir = DIR_NEG;
      end
    end
  end
endmodule

// File: rtl/enoc_adaptive_route_calc.sv
// Minimal adaptive route calculator: registers one output-port request per
// accepted destination and falls back to dimension order after a long stall.
module enoc_adaptive_route_calc
  import enoc_pkg::*;
#(
  parameter int X_NODES    = 4,
  parameter int Y_NODES    = 4,
  parameter int X_LOC      = 0,
  parameter int Y_LOC      = 0,
  parameter int TORUS      = 0,
  parameter int ADAPTIVE   = 1,
  parameter int CW         = 3,
  parameter int ESC_THRESH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  enoc_adaptive_route_calc_if.slave   rif
);
  localparam int XW   = log2(X_NODES);
  localparam int YW   = log2(Y_NODES);
  localparam int CNTW = log2(ESC_THRESH + 1);

  localparam logic [XW:0]     XN_V = X_NODES[XW:0];
  localparam logic [YW:0]     YN_V = Y_NODES[YW:0];
  localparam logic [CNTW-1:0] THR  = ESC_THRESH[CNTW-1:0];

  localparam bit WRAP_E = (TORUS != 0) && (X_LOC == X_NODES - 1);
  localparam bit WRAP_W = (TORUS != 0) && (X_LOC == 0);
  localparam bit WRAP_N = (TORUS != 0) && (Y_LOC == Y_NODES - 1);
  localparam bit WRAP_S = (TORUS != 0) && (Y_LOC == 0);

  function automatic logic wrap_of(input logic [4:0] oh);
    return ((oh == OH_E) && WRAP_E) || ((oh == OH_W) && WRAP_W) ||
           ((oh == OH_N) && WRAP_N) || ((oh == OH_S) && WRAP_S);
  endfunction

  dir_e x_dir, y_dir;

  enoc_dim_dir #(.N(X_NODES), .LOC(X_LOC), .TORUS(TORUS), .W(XW)) u_x_dir (
    .dest (rif.i_x_dest),
    .dir  (x_dir)
  );

  enoc_dim_dir #(.N(Y_NODES), .LOC(Y_LOC), .TORUS(TORUS), .W(YW)) u_y_dir (
    .dest (rif.i_y_dest),
    .dir  (y_dir)
  );

  logic            dest_err;
  logic [4:0]      x_oh, y_oh, dor_oh, route_oh;
  logic [CW-1:0]   cred_x, cred_y;

  always_comb begin
    dest_err = ({1'b0, rif.i_x_dest} >= XN_V) || ({1'b0, rif.i_y_dest} >= YN_V);
    x_oh     = (x_dir == DIR_POS) ? port_oh(P_E) : (x_dir == DIR_NEG) ? port_oh(P_W) : OH_NONE;
    y_oh     = (y_dir == DIR_POS) ? port_oh(P_N) : (y_dir == DIR_NEG) ? port_oh(P_S) : OH_NONE;
    cred_x   = (x_dir == DIR_POS) ? rif.i_credit[2*CW +: CW] : rif.i_credit[0 +: CW];
    cred_y   = (y_dir == DIR_POS) ? rif.i_credit[3*CW +: CW] : rif.i_credit[CW +: CW];
    if (dest_err || (x_oh == OH_NONE && y_oh == OH_NONE)) dor_oh = OH_C;
    else if (x_oh != OH_NONE)                             dor_oh = x_oh;
    else                                                  dor_oh = y_oh;
    route_oh = dor_oh;
    if ((ADAPTIVE != 0) && !dest_err && (x_oh != OH_NONE) && (y_oh != OH_NONE) &&
        (cred_y > cred_x))
      route_oh = y_oh;
  end

  state_e          state_q, state_d;
  logic [4:0]      req_q, req_d, dor_q, dor_d;
  logic            wrap_q, wrap_d, err_q, err_d;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            rdy, accept;

  assign rdy    = (state_q == ST_IDLE) || rif.i_rdy;
  assign accept = rif.i_val && rdy;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    dor_d   = dor_q;
    wrap_d  = wrap_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == THR) ? cnt_q : cnt_q + 1'b1;
    if (state_q != ST_IDLE && !rif.i_rdy) begin
      cnt_d = cnt_inc;
      if (state_q == ST_HOLD && cnt_inc == THR && req_q != dor_q) begin
        state_d = ST_ESCAPE;
        req_d   = dor_q;
        wrap_d  = wrap_of(dor_q);
      end
    end else if (accept) begin
      state_d = ST_HOLD;
      req_d   = route_oh;
      dor_d   = dor_oh;
      wrap_d  = wrap_of(route_oh);
      err_d   = dest_err;
      cnt_d   = '0;
    end else begin
      state_d = ST_IDLE;
      req_d   = OH_NONE;
      dor_d   = OH_NONE;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      req_q   <= OH_NONE;
      dor_q   <= OH_NONE;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      dor_q   <= dor_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rif.o_rdy        = rdy;
  assign rif.o_val        = (state_q != ST_IDLE);
  assign rif.o_output_req = req_q;
  assign rif.o_wrap       = wrap_q;
  assign rif.o_err        = err_q;
endmodule

// File: tb/tb_enoc_adaptive_route_calc.sv
// Drives three route calculator configurations in lockstep and compares each
// against a distance-based routing model.
module tb_enoc_adaptive_route_calc;
  import enoc_pkg::*;

  localparam int ND = 3;
  localparam int CXN[ND] = '{4, 4, 5};
  localparam int CYN[ND] = '{4, 4, 1};
  localparam int CXL[ND] = '{1, 0, 4};
  localparam int CYL[ND] = '{1, 0, 0};
  localparam int CTR[ND] = '{0, 1, 1};
  localparam int CAD[ND] = '{1, 1, 0};
  localparam int THR     = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  x_dest;
  logic [1:0]  y_dest;
  logic        val, rdy;
  logic [11:0] credit;

  always #5 clk = ~clk;

  enoc_adaptive_route_calc_if #(.XW(2), .YW(2), .CW(3)) if0 ();
  enoc_adaptive_route_calc_if #(.XW(2), .YW(2), .CW(3)) if1 ();
  enoc_adaptive_route_calc_if #(.XW(3), .YW(1), .CW(3)) if2 ();

  assign if0.i_x_dest = x_dest[1:0];
  assign if0.i_y_dest = y_dest;
  assign if0.i_val    = val;
  assign if0.i_credit = credit;
  assign if0.i_rdy    = rdy;
  assign if1.i_x_dest = x_dest[1:0];
  assign if1.i_y_dest = y_dest;
  assign if1.i_val    = val;
  assign if1.i_credit = credit;
  assign if1.i_rdy    = rdy;
  assign if2.i_x_dest = x_dest;
  assign if2.i_y_dest = y_dest[0];
  assign if2.i_val    = val;
  assign if2.i_credit = credit;
  assign if2.i_rdy    = rdy;

  enoc_adaptive_route_calc #(.X_NODES(CXN[0]), .Y_NODES(CYN[0]), .X_LOC(CXL[0]), .Y_LOC(CYL[0]),
    .TORUS(CTR[0]), .ADAPTIVE(CAD[0]), .CW(3), .ESC_THRESH(THR)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .rif(if0.slave));
  enoc_adaptive_route_calc #(.X_NODES(CXN[1]), .Y_NODES(CYN[1]), .X_LOC(CXL[1]), .Y_LOC(CYL[1]),
    .TORUS(CTR[1]), .ADAPTIVE(CAD[1]), .CW(3), .ESC_THRESH(THR)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .rif(if1.slave));
  enoc_adaptive_route_calc #(.X_NODES(CXN[2]), .Y_NODES(CYN[2]), .X_LOC(CXL[2]), .Y_LOC(CYL[2]),
    .TORUS(CTR[2]), .ADAPTIVE(CAD[2]), .CW(3), .ESC_THRESH(THR)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .rif(if2.slave));

  logic [4:0] o_req [ND];
  logic       o_v [ND], o_w [ND], o_e [ND], o_r [ND];
  assign o_req[0] = if0.o_output_req; assign o_v[0] = if0.o_val; assign o_w[0] = if0.o_wrap;
  assign o_e[0]   = if0.o_err;        assign o_r[0] = if0.o_rdy;
  assign o_req[1] = if1.o_output_req; assign o_v[1] = if1.o_val; assign o_w[1] = if1.o_wrap;
  assign o_e[1]   = if1.o_err;        assign o_r[1] = if1.o_rdy;
  assign o_req[2] = if2.o_output_req; assign o_v[2] = if2.o_val; assign o_w[2] = if2.o_wrap;
  assign o_e[2]   = if2.o_err;        assign o_r[2] = if2.o_rdy;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // expected state per configuration
  logic       ev [ND];
  logic [4:0] ereq [ND], edor [ND];
  logic       ewrap [ND], eerr [ND];
  int         ecnt [ND];

  // +1 positive, -1 negative, 0 none, by hop distance
  function automatic int dim_dir(input int n, input int l, input int d, input int tor);
    int fwd;
    if (n == 1) return 0;
    if (tor != 0) begin
      fwd = ((d - l) % n + n) % n;
      if (fwd == 0) return 0;
      return (fwd <= n - fwd) ? 1 : -1;
    end
    if (d > l) return 1;
    if (d < l) return -1;
    return 0;
  endfunction

  function automatic int cred_of(input logic [4:0] p, input logic [11:0] cr);
    case (p)
      5'b01000: return int'(cr[11:9]);
      5'b00100: return int'(cr[8:6]);
      5'b00010: return int'(cr[5:3]);
      default:  return int'(cr[2:0]);
    endcase
  endfunction

  function automatic logic wrap_m(input int k, input logic [4:0] p);
    if (CTR[k] == 0) return 1'b0;
    return (p == 5'b00100 && CXL[k] == CXN[k] - 1) || (p == 5'b00001 && CXL[k] == 0) ||
           (p == 5'b01000 && CYL[k] == CYN[k] - 1) || (p == 5'b00010 && CYL[k] == 0);
  endfunction

  task automatic route_m(input int k, input int xd, input int yd, input logic [11:0] cr,
                         output logic [4:0] req, output logic [4:0] dor, output logic err);
    int dx, dy;
    logic [4:0] xp, yp;
    err = (xd >= CXN[k]) || (yd >= CYN[k]);
    if (err) begin
      req = 5'b10000; dor = 5'b10000;
      return;
    end
    dx = dim_dir(CXN[k], CXL[k], xd, CTR[k]);
    dy = dim_dir(CYN[k], CYL[k], yd, CTR[k]);
    xp = (dx > 0) ? 5'b00100 : (dx < 0) ? 5'b00001 : 5'b00000;
    yp = (dy > 0) ? 5'b01000 : (dy < 0) ? 5'b00010 : 5'b00000;
    if (xp == 0 && yp == 0) dor = 5'b10000;
    else if (xp != 0)       dor = xp;
    else                    dor = yp;
    req = dor;
    if (CAD[k] != 0 && xp != 0 && yp != 0 && cred_of(yp, cr) > cred_of(xp, cr)) req = yp;
  endtask

  task automatic model_update(input int k);
    int xd, yd;
    logic [4:0] r, d;
    logic e;
    xd = (k == 2) ? int'(x_dest) : int'(x_dest[1:0]);
    yd = (k == 2) ? int'(y_dest[0]) : int'(y_dest);
    if (!reset_n) begin
      ev[k] = 1'b0; ereq[k] = 5'b0; edor[k] = 5'b0; ewrap[k] = 1'b0; eerr[k] = 1'b0; ecnt[k] = 0;
    end else if (ev[k] && !rdy) begin
      if (ecnt[k] < THR) ecnt[k]++;
      if (ecnt[k] == THR && ereq[k] != edor[k]) begin
        ereq[k]  = edor[k];
        ewrap[k] = wrap_m(k, edor[k]);
      end
    end else if (val) begin
      route_m(k, xd, yd, credit, r, d, e);
      ev[k] = 1'b1; ereq[k] = r; edor[k] = d; eerr[k] = e; ewrap[k] = wrap_m(k, r); ecnt[k] = 0;
    end else begin
      ev[k] = 1'b0; ecnt[k] = 0;
    end
  endtask

  task automatic step();
    #1;
    for (int k = 0; k < ND; k++) chk($sformatf("rdy%0d", k), 32'(o_r[k]), 32'(!ev[k] || rdy));
    @(posedge clk);
    for (int k = 0; k < ND; k++) model_update(k);
    #1;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("val%0d", k), 32'(o_v[k]), 32'(ev[k]));
      if (ev[k]) begin
        chk($sformatf("req%0d", k), 32'(o_req[k]), 32'(ereq[k]));
        chk($sformatf("wrap%0d", k), 32'(o_w[k]), 32'(ewrap[k]));
        chk($sformatf("err%0d", k), 32'(o_e[k]), 32'(eerr[k]));
      end
    end
  endtask

  task automatic send(input int x, input int y, input logic [11:0] cr);
    x_dest = 3'(x); y_dest = 2'(y); credit = cr; val = 1'b1; rdy = 1'b1;
    step();
    val = 1'b0;
  endtask

  int pct [3] = '{90, 50, 5};

  initial begin
    for (int k = 0; k < ND; k++) begin
      ev[k] = 1'b0; ereq[k] = 5'b0; edor[k] = 5'b0; ewrap[k] = 1'b0; eerr[k] = 1'b0; ecnt[k] = 0;
    end
    reset_n = 1'b0; x_dest = '0; y_dest = '0; val = 1'b0; rdy = 1'b0; credit = '0;
    repeat (3) step();
    chk("reset_val", 32'(if0.o_val), 32'd0);
    chk("reset_req", 32'(if0.o_output_req), 32'd0);
    chk("reset_rdy", 32'(if0.o_rdy), 32'd1);
    reset_n = 1'b1;
    step();

    // mesh (1,1): straight east, then local
    send(3, 0, 12'h000);
    chk("mesh_east", 32'(if0.o_output_req), 32'b00100);
    send(1, 1, 12'h000);
    chk("mesh_local", 32'(if0.o_output_req), 32'b10000);

    // torus (0,0): wrap west, then tie resolves east
    send(3, 0, 12'h000);
    chk("torus_west", 32'(if1.o_output_req), 32'b00001);
    chk("torus_wrap", 32'(if1.o_wrap), 32'd1);
    send(2, 0, 12'h000);
    chk("torus_tie", 32'(if1.o_output_req), 32'b00100);
    chk("torus_nowrap", 32'(if1.o_wrap), 32'd0);

    // adaptive choice by credit {n,e,s,w}
    send(3, 3, {3'd1, 3'd5, 6'd0});
    chk("adapt_e", 32'(if0.o_output_req), 32'b00100);
    send(3, 3, {3'd5, 3'd5, 6'd0});
    chk("adapt_tie", 32'(if0.o_output_req), 32'b00100);
    send(3, 3, {3'd5, 3'd0, 6'd0});
    chk("adapt_n", 32'(if0.o_output_req), 32'b01000);

    // stall past the threshold: north falls back to east and stays there
    send(3, 3, {3'd5, 3'd0, 6'd0});
    rdy = 1'b0;
    for (int i = 0; i < THR - 1; i++) begin
      credit = 12'($urandom);
      step();
    end
    chk("esc_before", 32'(if0.o_output_req), 32'b01000);
    step();
    chk("esc_switch", 32'(if0.o_output_req), 32'b00100);
    repeat (4) step();
    chk("esc_hold", 32'(if0.o_output_req), 32'b00100);
    rdy = 1'b1;
    step();
    chk("esc_done", 32'(if0.o_val), 32'd0);

    // back-to-back accepts without a bubble
    val = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x_dest = 3'($urandom_range(0, 3)); y_dest = 2'($urandom); credit = 12'($urandom);
      step();
      chk("b2b_val", 32'(if0.o_val), 32'd1);
    end
    val = 1'b0;

    // reset while holding drops the request
    send(3, 3, 12'h000);
    rdy = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    chk("rst_hold", 32'(if0.o_val), 32'd0);
    reset_n = 1'b1;

    // out-of-range destination on the 5x1 ring
    send(5, 0, 12'h000);
    chk("err_req", 32'(if2.o_output_req), 32'b10000);
    chk("err_flag", 32'(if2.o_err), 32'd1);
    send(4, 1, 12'h000);
    chk("err_y", 32'(if2.o_err), 32'd1);
    send(1, 0, 12'h000);
    chk("ring_e_wrap", 32'(if2.o_wrap), 32'd1);

    for (int seg = 0; seg < 24; seg++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 100; i++) begin
        rdy     = ($urandom_range(0, 99) < pct[mode]);
        val     = ($urandom_range(0, 9) < 7);
        x_dest  = 3'($urandom_range(0, 7));
        y_dest  = 2'($urandom_range(0, 3));
        credit  = 12'($urandom);
        reset_n = ($urandom_range(0, 299) != 0);
        step();
      end
    end
    reset_n = 1'b1; val = 1'b0; rdy = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
